apb_master_mc: RTL

Parametrised multi-slave APB4 master. It accepts transfer commands from the external system into a small command FIFO and drives them as APB SETUP/ACCESS sequences to one of NUM_SLAVES decoded slaves. It adds byte strobes, back-to-back transfers, address-decode errors and a wait-state timeout. It sits between the system-side command port and the APB slave fabric, and replaces the single-slave master.

---
 rtl/apb_master_mc.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/apb_master_mc.sv
// apb_master_mc: multi-slave APB4 master with command FIFO,
// byte strobes, decode errors and wait-state timeout.
`timescale 1ns/1ps
module apb_master_mc #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int SEL_LSB        = 12,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                             PCLK,
  input  logic                             PRESETn,
  input  logic                             start_transfer,
  output logic                             cmd_ready,
  input  logic                             wr,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [DATA_WIDTH/8-1:0]          strb,
  output logic                             done,
  output logic [DATA_WIDTH-1:0]            rdata,
  output logic                             slverr,
  output logic                             timeout,
  output logic [NUM_SLAVES-1:0]            PSEL,
  output logic                             PENABLE,
  output logic                             PWRITE,
  output logic [ADDR_WIDTH-1:0]            PADDR,
  output logic [DATA_WIDTH-1:0]            PWDATA,
  output logic [DATA_WIDTH/8-1:0]          PSTRB,
  input  logic [NUM_SLAVES-1:0]            PREADY,
  input  logic [NUM_SLAVES-1:0]            PSLVERR,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA
);

  localparam int SW = $clog2(NUM_SLAVES);
  localparam int BW = DATA_WIDTH / 8;
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS
  } state_t;

  logic                  r_q_wr    [CMD_DEPTH];
  logic [ADDR_WIDTH-1:0] r_q_addr  [CMD_DEPTH];
  logic [DATA_WIDTH-1:0] r_q_wdata [CMD_DEPTH];
  logic [BW-1:0]         r_q_strb  [CMD_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [PW:0]           r_cnt;

  state_t                r_state;
  logic                  r_err_pend;
  logic [TW-1:0]         r_wait;
  logic [NUM_SLAVES-1:0] r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pwdata;
  logic [BW-1:0]         r_pstrb;
  logic                  r_done;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_slverr;
  logic                  r_timeout;

  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_h_wr;
  logic [ADDR_WIDTH-1:0] w_h_addr;
  logic [DATA_WIDTH-1:0] w_h_wdata;
  logic [BW-1:0]         w_h_strb;
  logic [SW-1:0]         w_h_idx;
  logic                  w_h_ok;
  logic [NUM_SLAVES-1:0] w_ld_psel;
  logic                  w_rdy;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_prdata;

  assign w_full    = (r_cnt == (PW+1)'(CMD_DEPTH));
  assign cmd_ready = !w_full;
  assign w_push    = start_transfer && !w_full;

  assign w_h_wr    = r_q_wr[r_rptr];
  assign w_h_addr  = r_q_addr[r_rptr];
  assign w_h_wdata = r_q_wdata[r_rptr];
  assign w_h_strb  = r_q_strb[r_rptr];
  assign w_h_idx   = w_h_addr[SEL_LSB +: SW];
  assign w_h_ok    = ({1'b0, w_h_idx} < (SW+1)'(NUM_SLAVES));
  assign w_ld_psel = (NUM_SLAVES)'(1) << w_h_idx;

  // Only the currently selected slave's response is observed.
  always_comb begin
    w_rdy    = |(PREADY & r_psel);
    w_err    = |(PSLVERR & r_psel);
    w_prdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_psel[i]) w_prdata |= PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_pop = (r_cnt != '0) && !r_err_pend &&
                 ((r_state == S_IDLE) ||
                  ((r_state == S_ACCESS) && w_rdy));

  always_ff @(posedge PCLK) begin
    if (w_push) begin
      r_q_wr[r_wptr]    <= wr;
      r_q_addr[r_wptr]  <= addr;
      r_q_wdata[r_wptr] <= wdata;
      r_q_strb[r_wptr]  <= strb;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_cnt <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state    <= S_IDLE;
      r_err_pend <= 1'b0;
      r_wait     <= '0;
      r_psel     <= '0;
      r_penable  <= 1'b0;
      r_pwrite   <= 1'b0;
      r_paddr    <= '0;
      r_pwdata   <= '0;
      r_pstrb    <= '0;
      r_done     <= 1'b0;
      r_rdata    <= '0;
      r_slverr   <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_rdata   <= '0;
      r_slverr  <= 1'b0;
      r_timeout <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (r_err_pend) begin
            r_err_pend <= 1'b0;
            r_done     <= 1'b1;
            r_slverr   <= 1'b1;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_rdy) begin
            r_done    <= 1'b1;
            r_slverr  <= w_err;
            r_rdata   <= r_pwrite ? '0 : w_prdata;
            r_state   <= S_IDLE;
            r_psel    <= '0;
            r_penable <= 1'b0;
          end else if (r_wait == TW'(TIMEOUT_CYCLES - 1)) begin
            r_done    <= 1'b1;
            r_slverr  <= 1'b1;
            r_timeout <= 1'b1;
            r_state   <= S_IDLE;
            r_psel    <= '0;
            r_penable <= 1'b0;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      // A pop overrides the IDLE fallback so transfers chain directly.
      if (w_pop) begin
        r_penable <= 1'b0;
        if (w_h_ok) begin
          r_state  <= S_SETUP;
          r_psel   <= w_ld_psel;
          r_pwrite <= w_h_wr;
          r_paddr  <= w_h_addr;
          r_pwdata <= w_h_wr ? w_h_wdata : '0;
          r_pstrb  <= w_h_wr ? w_h_strb : '0;
          r_wait   <= '0;
        end else begin
          r_state    <= S_IDLE;
          r_psel     <= '0;
          r_err_pend <= 1'b1;
        end
      end
    end
  end

  assign PSEL    = r_psel;
  assign PENABLE = r_penable;
  assign PWRITE  = r_pwrite;
  assign PADDR   = r_paddr;
  assign PWDATA  = r_pwdata;
  assign PSTRB   = r_pstrb;
  assign done    = r_done;
  assign rdata   = r_rdata;
  assign slverr  = r_slverr;
  assign timeout = r_timeout;

endmodule
